block_assembler: RTL and testbench

//  Pops IN_W-bit words from a show-ahead data FIFO and packs them into one BLOCK_W-bit block.

---
 rtl/block_assembler_if.sv | 36 +++
 rtl/block_assembler.sv | 119 +++++++++++
 tb/tb_block_assembler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_assembler_if.sv
// Word-in / block-out bundle for block_assembler. master = assembler side, slave = FIFO/consumer side.
// blk_nbeats is only present when PARTIAL_FLUSH_EN is defined.
interface block_assembler_if #(
   parameter int IN_W    = 8,
   parameter int BLOCK_W = 128
);
`ifdef PARTIAL_FLUSH_EN
   localparam int BEATS = BLOCK_W / IN_W;
   localparam int NB_W  = $clog2(BEATS + 1);
   logic [NB_W-1:0]    blk_nbeats;
`endif
   logic               fifo_empty;
   logic [IN_W-1:0]    fifo_data;
   logic               fifo_pop;
   logic               flush;
   logic               blk_valid;
   logic               blk_ready;
   logic [BLOCK_W-1:0] blk_data;
   logic               busy;

   modport master (
      input  fifo_empty, fifo_data, flush, blk_ready,
`ifdef PARTIAL_FLUSH_EN
      output blk_nbeats,
`endif
      output fifo_pop, blk_valid, blk_data, busy
   );

   modport slave (
      output fifo_empty, fifo_data, flush, blk_ready,
`ifdef PARTIAL_FLUSH_EN
      input  blk_nbeats,
`endif
      input  fifo_pop, blk_valid, blk_data, busy
   );
endinterface

// File: rtl/block_assembler.sv
// Packs IN_W-bit words from a show-ahead FIFO into BLOCK_W-bit blocks behind a valid/ready handshake.
// Optional PARTIAL_FLUSH_EN: flush emits the partial block (zero-padded) with a beat count.
module block_assembler #(
   parameter int IN_W      = 8,
   parameter int BLOCK_W   = 128,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic clk,
   input  logic rst,
   block_assembler_if.master bus
);
   localparam int BEATS = BLOCK_W / IN_W;
   localparam int CNT_W = $clog2(BEATS);

   typedef enum logic {FILL, HOLD} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [BLOCK_W-1:0] data_reg, data_next;
   logic               valid_reg, valid_next;
   logic               pop;
   logic               last;
   logic [BEATS-1:0]   wr_sel;

`ifdef PARTIAL_FLUSH_EN
   localparam int NB_W = $clog2(BEATS + 1);
   logic [NB_W-1:0]    nbeats_reg, nbeats_next;
   logic [BEATS-1:0]   filled;
`endif

   // Map each slot to the beat number that lands in it, so the packing order is a constant per slot.
   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_slot
         localparam int BEAT = MSB_FIRST ? (BEATS - 1 - gi) : gi;
         assign wr_sel[gi] = (count_reg == CNT_W'(BEAT));
`ifdef PARTIAL_FLUSH_EN
         assign filled[gi] = (count_reg > CNT_W'(BEAT));
`endif
      end
   endgenerate

   assign pop  = (state_reg == FILL) && !bus.fifo_empty && !bus.flush && !rst;
   assign last = (count_reg == CNT_W'(BEATS - 1));

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      data_next   = data_reg;
      valid_next  = valid_reg;
`ifdef PARTIAL_FLUSH_EN
      nbeats_next = nbeats_reg;
`endif
      case (state_reg)
         FILL: begin
            if (bus.flush) begin
               count_next = '0;
`ifdef PARTIAL_FLUSH_EN
               if (count_reg != '0) begin
                  for (int i = 0; i < BEATS; i++)
                     if (!filled[i]) data_next[i*IN_W +: IN_W] = '0;
                  nbeats_next = NB_W'(count_reg);
                  valid_next  = 1'b1;
                  state_next  = HOLD;
               end
`endif
            end else if (pop) begin
               for (int i = 0; i < BEATS; i++)
                  if (wr_sel[i]) data_next[i*IN_W +: IN_W] = bus.fifo_data;
               if (last) begin
                  count_next = '0;
                  valid_next = 1'b1;
                  state_next = HOLD;
`ifdef PARTIAL_FLUSH_EN
                  nbeats_next = NB_W'(BEATS);
`endif
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (bus.blk_ready) begin
               valid_next = 1'b0;
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= FILL;
         count_reg  <= '0;
         data_reg   <= '0;
         valid_reg  <= 1'b0;
`ifdef PARTIAL_FLUSH_EN
         nbeats_reg <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         data_reg   <= data_next;
         valid_reg  <= valid_next;
`ifdef PARTIAL_FLUSH_EN
         nbeats_reg <= nbeats_next;
`endif
      end
   end

   assign bus.fifo_pop  = pop;
   assign bus.blk_valid = valid_reg;
   assign bus.blk_data  = data_reg;
   assign bus.busy      = (count_reg != '0) || valid_reg;
`ifdef PARTIAL_FLUSH_EN
   assign bus.blk_nbeats = nbeats_reg;
`endif
endmodule

// File: tb/tb_block_assembler.sv
// Bench for block_assembler: two instances (8b MSB-first and 32b LSB-first), queue-fed FIFOs,
// a per-cycle word-list model and literal expectations for each directed scenario.
module tb_block_assembler;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   block_assembler_if #(.IN_W(8),  .BLOCK_W(128)) bus0();
   block_assembler_if #(.IN_W(32), .BLOCK_W(128)) bus1();

   block_assembler #(.IN_W(8),  .BLOCK_W(128), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   block_assembler #(.IN_W(32), .BLOCK_W(128), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // FIFO contents and stall control
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   bit stall0 = 1'b0;
   bit stall1 = 1'b0;
   bit popped0 = 1'b0;
   bit popped1 = 1'b0;

   initial begin
      bus0.fifo_empty = 1'b1; bus0.fifo_data = '0;
      bus1.fifo_empty = 1'b1; bus1.fifo_data = '0;
      forever begin
         @(posedge clk);
         #2;
         if (popped0 && q0.size() > 0) void'(q0.pop_front());
         if (popped1 && q1.size() > 0) void'(q1.pop_front());
         bus0.fifo_empty = stall0 || (q0.size() == 0);
         bus0.fifo_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
         bus1.fifo_empty = stall1 || (q1.size() == 0);
         bus1.fifo_data  = (q1.size() > 0) ? q1[0] : 32'h0;
      end
   end

   // Model: list of words collected for the current block, plus the block awaiting handshake.
   int          mn[2]    = '{0, 0};
   logic [31:0] mw[2][16];
   bit          mheld[2] = '{1'b0, 1'b0};
   logic [127:0] mblk[2];
   int          mnb[2]   = '{0, 0};

   function automatic logic [127:0] pack(input int d);
      logic [127:0] b = '0;
      int beats = (d == 0) ? 16 : 4;
      int w     = (d == 0) ? 8 : 32;
      for (int i = 0; i < mn[d]; i++) begin
         int slot = (d == 0) ? (beats - 1 - i) : i;
         b = b | (128'(mw[d][i]) << (slot * w));
      end
      return b;
   endfunction

   task automatic model_step(input int d, input logic empty, input logic flush, input logic ready,
                             input logic [31:0] word, input logic a_pop, input logic a_valid,
                             input logic a_busy, input logic [127:0] a_data, input int a_nb);
      string tag = (d == 0) ? "d0" : "d1";
      int beats = (d == 0) ? 16 : 4;
      logic exp_pop;
      if (rst) begin
         chk({tag, " rst pop"},   a_pop,   0);
         chk({tag, " rst valid"}, a_valid, 0);
         chk({tag, " rst busy"},  a_busy,  0);
         chk({tag, " rst data"},  a_data,  0);
`ifdef PARTIAL_FLUSH_EN
         chk({tag, " rst nbeats"}, 128'(a_nb), 0);
`endif
         mn[d] = 0; mheld[d] = 1'b0;
         return;
      end
      exp_pop = !mheld[d] && !empty && !flush;
      chk({tag, " pop"},   a_pop,   exp_pop);
      chk({tag, " valid"}, a_valid, mheld[d]);
      chk({tag, " busy"},  a_busy,  mheld[d] || (mn[d] != 0));
      if (mheld[d]) begin
         chk({tag, " data"}, a_data, mblk[d]);
`ifdef PARTIAL_FLUSH_EN
         chk({tag, " nbeats"}, 128'(a_nb), 128'(mnb[d]));
`endif
      end
      if (mheld[d]) begin
         if (ready) mheld[d] = 1'b0;
      end else if (flush) begin
`ifdef PARTIAL_FLUSH_EN
         if (mn[d] > 0) begin
            mblk[d] = pack(d); mnb[d] = mn[d]; mheld[d] = 1'b1;
         end
`endif
         mn[d] = 0;
      end else if (exp_pop) begin
         mw[d][mn[d]] = word;
         mn[d]++;
         if (mn[d] == beats) begin
            mblk[d] = pack(d); mnb[d] = beats; mheld[d] = 1'b1; mn[d] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      int nb0, nb1;
`ifdef PARTIAL_FLUSH_EN
      nb0 = int'(bus0.blk_nbeats);
      nb1 = int'(bus1.blk_nbeats);
`else
      nb0 = 0;
      nb1 = 0;
`endif
      popped0 = bus0.fifo_pop;
      popped1 = bus1.fifo_pop;
      model_step(0, bus0.fifo_empty, bus0.flush, bus0.blk_ready, 32'(bus0.fifo_data),
                 bus0.fifo_pop, bus0.blk_valid, bus0.busy, bus0.blk_data, nb0);
      model_step(1, bus1.fifo_empty, bus1.flush, bus1.blk_ready, bus1.fifo_data,
                 bus1.fifo_pop, bus1.blk_valid, bus1.busy, bus1.blk_data, nb1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++)
         if (d == 0) q0.push_back(first + 32'(i)); else q1.push_back(first + 32'(i));
   endtask

   task automatic wait_empty0(input string name);
      int t = 0;
      while (q0.size() != 0 && t < 200) begin tick(); t++; end
      chk({name, " drain"}, 128'(q0.size()), 0);
   endtask

   task automatic wait_valid(input int d, input string name, input logic [127:0] exp);
      int t = 0;
      while (!((d == 0) ? bus0.blk_valid : bus1.blk_valid) && t < 100) begin tick(); t++; end
      $display("%s: waited %0d cycles for block", name, t);
      chk({name, " valid"}, (d == 0) ? bus0.blk_valid : bus1.blk_valid, 1);
      chk({name, " data"},  (d == 0) ? bus0.blk_data  : bus1.blk_data,  exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus0.flush = 1'b0; bus0.blk_ready = 1'b1;
      bus1.flush = 1'b0; bus1.blk_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // 1: sixteen bytes straight through
      push(0, 32'h00, 16);
      wait_valid(0, "s1", 128'h000102030405060708090A0B0C0D0E0F);
      tick();
      chk("s1 single hold cycle", bus0.blk_valid, 0);

      // 2: consumer stalls 5 cycles; flush during HOLD ignored; next block queued behind it
      bus0.blk_ready = 1'b0;
      push(0, 32'h20, 16);
      wait_valid(0, "s2", 128'h202122232425262728292A2B2C2D2E2F);
      push(0, 32'h40, 16);
      for (int i = 0; i < 5; i++) begin
         bus0.flush = (i == 2);
         tick();
         chk("s2 held valid", bus0.blk_valid, 1);
         chk("s2 held data", bus0.blk_data, 128'h202122232425262728292A2B2C2D2E2F);
         chk("s2 held pop", bus0.fifo_pop, 0);
      end
      bus0.flush = 1'b0;
      bus0.blk_ready = 1'b1;
      tick();
      chk("s2 handshake", bus0.blk_valid, 0);
      wait_valid(0, "s2 next", 128'h404142434445464748494A4B4C4D4E4F);
      tick();

      // 3: FIFO runs dry after 7 bytes for 10 cycles
      push(0, 32'h00, 7);
      wait_empty0("s3");
      stall0 = 1'b1;
      push(0, 32'h07, 9);
      repeat (10) tick();
      chk("s3 stalled busy", bus0.busy, 1);
      stall0 = 1'b0;
      wait_valid(0, "s3", 128'h000102030405060708090A0B0C0D0E0F);
      tick();

      // 4: flush after 5 bytes
      push(0, 32'hE0, 5);
      wait_empty0("s4");
      bus0.flush = 1'b1;
      tick();
      bus0.flush = 1'b0;
      push(0, 32'h10, 16);
`ifdef PARTIAL_FLUSH_EN
      wait_valid(0, "s4 partial", 128'hE0E1E2E3_E4000000_00000000_00000000);
      chk("s4 partial nbeats", 128'(bus0.blk_nbeats), 5);
      tick();
`endif
      wait_valid(0, "s4", 128'h101112131415161718191A1B1C1D1E1F);
      tick();

      // 5: reset mid-block
      push(0, 32'h30, 9);
      wait_empty0("s5");
      rst = 1'b1;
      tick();
      chk("s5 rst valid", bus0.blk_valid, 0);
      chk("s5 rst pop", bus0.fifo_pop, 0);
      chk("s5 rst busy", bus0.busy, 0);
      tick();
      rst = 1'b0;
      push(0, 32'hA0, 16);
      wait_valid(0, "s5", 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      tick();

      // 6: 32-bit LSB-first instance; flush with nothing collected emits nothing
      push(1, 32'h1, 4);
      wait_valid(1, "s6", 128'h00000004_00000003_00000002_00000001);
      tick();
      bus0.flush = 1'b1;
      tick();
      bus0.flush = 1'b0;
      tick();
      chk("s6 empty flush no block", bus0.blk_valid, 0);
`ifdef PARTIAL_FLUSH_EN
      q0.push_back(32'h11); q0.push_back(32'h22); q0.push_back(32'h33);
      wait_empty0("s6p");
      bus0.flush = 1'b1;
      tick();
      bus0.flush = 1'b0;
      wait_valid(0, "s6 partial", 128'h11223300_00000000_00000000_00000000);
      chk("s6 partial nbeats", 128'(bus0.blk_nbeats), 3);
      tick();
`endif
      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
